spm_resp: RTL and testbench

Scratchpad-memory responder: the target end of the SPM interface driven by the MEM stage, plus a read-only instruction-fetch port. Both ports share one single-port word array. The data port always wins arbitration; a colliding fetch is deferred one or more cycles and signalled to the IF stage through `spm_busy`. Read data is registered and returned the cycle after the request.

---
 rtl/spm_resp_pkg.sv | 22 ++
 rtl/spm_resp_array.sv | 47 ++++
 rtl/spm_resp.sv | 148 ++++++++++++++
 tb/tb_spm_resp.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/spm_resp_pkg.sv
// Shared constants, arbitration state encoding and parity helper for the scratchpad responder.
// Optional feature macro: SPM_PARITY_EN (per-word even parity with sticky error flag).
package spm_resp_pkg;

    localparam int WORD_DATA_W   = 32;
    localparam int WORD_ADDR_W   = 30;
    localparam int SPM_DEPTH_DEF = 4096;
    localparam int SPM_AW_DEF    = 12;

    localparam logic SPM_READ  = 1'b1;
    localparam logic SPM_WRITE = 1'b0;

    typedef enum logic [0:0] {
        SPM_ST_IDLE   = 1'b0,
        SPM_ST_I_WAIT = 1'b1
    } spm_state_e;

    function automatic logic spm_parity(input logic [WORD_DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/spm_resp_array.sv
// Single-port scratchpad word array: synchronous write, combinational read (write-first across cycles).
// With SPM_PARITY_EN each word carries an even-parity bit and a mismatch flag is reported on read.
module spm_resp_array
    import spm_resp_pkg::*;
#(
    parameter int DEPTH = SPM_DEPTH_DEF,
    parameter int AW    = SPM_AW_DEF
) (
    input  logic                   clk,
    input  logic                   i_we,
    input  logic [AW-1:0]          i_addr,
    input  logic [WORD_DATA_W-1:0] i_wdata,
    output logic [WORD_DATA_W-1:0] o_rdata
`ifdef SPM_PARITY_EN
    ,
    output logic                   o_perr
`endif
);

`ifdef SPM_PARITY_EN
    logic [WORD_DATA_W:0] r_mem [DEPTH];
    logic [WORD_DATA_W:0] w_word;

    assign w_word  = r_mem[i_addr];
    assign o_rdata = w_word[WORD_DATA_W-1:0];
    assign o_perr  = spm_parity(w_word[WORD_DATA_W-1:0]) ^ w_word[WORD_DATA_W];

    // Store data together with its parity bit.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= {spm_parity(i_wdata), i_wdata};
        end
    end
`else
    logic [WORD_DATA_W-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    // Plain word store.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end
`endif

endmodule

// File: rtl/spm_resp.sv
// Scratchpad responder: data port (MEM stage) and read-only fetch port sharing one array.
// The data port always wins; a colliding fetch is parked in r_pend_addr. Macro: SPM_PARITY_EN.
module spm_resp
    import spm_resp_pkg::*;
#(
    parameter int SPM_DEPTH = SPM_DEPTH_DEF,
    parameter int SPM_AW    = SPM_AW_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WORD_ADDR_W-1:0] d_spm_addr,
    input  logic                   d_spm_as_,
    input  logic                   d_spm_rw,
    input  logic [WORD_DATA_W-1:0] d_spm_wr_data,
    output logic [WORD_DATA_W-1:0] d_spm_rd_data,
    input  logic [WORD_ADDR_W-1:0] i_spm_addr,
    input  logic                   i_spm_as_,
    output logic [WORD_DATA_W-1:0] i_spm_rd_data,
    output logic                   spm_busy
`ifdef SPM_PARITY_EN
    ,
    output logic                   spm_parity_err
`endif
);

    spm_state_e             r_state;
    logic [SPM_AW-1:0]      r_pend_addr;
    logic [WORD_DATA_W-1:0] r_d_rd_data;
    logic [WORD_DATA_W-1:0] r_i_rd_data;

    logic                   w_d_req;
    logic                   w_i_req;
    logic                   w_d_rd;
    logic                   w_d_wr;
    logic                   w_i_serve;
    logic [SPM_AW-1:0]      w_arr_addr;
    logic [WORD_DATA_W-1:0] w_arr_rdata;
    logic                   w_unused_addr;

    assign w_d_req       = ~d_spm_as_;
    assign w_i_req       = ~i_spm_as_;
    assign w_d_rd        = w_d_req & (d_spm_rw == SPM_READ);
    assign w_d_wr        = w_d_req & (d_spm_rw == SPM_WRITE);
    // Upper address bits are intentionally ignored: the array wraps modulo SPM_DEPTH.
    assign w_unused_addr = ^{d_spm_addr[WORD_ADDR_W-1:SPM_AW], i_spm_addr[WORD_ADDR_W-1:SPM_AW]};

    assign d_spm_rd_data = r_d_rd_data;
    assign i_spm_rd_data = r_i_rd_data;

    // Arbitration: pick the array address, decide whether the fetch port is served, drive busy.
    always_comb begin
        w_i_serve  = 1'b0;
        w_arr_addr = d_spm_addr[SPM_AW-1:0];
        spm_busy   = 1'b0;
        case (r_state)
            SPM_ST_IDLE: begin
                spm_busy = w_i_req & w_d_req;
                if (!w_d_req) begin
                    w_i_serve  = w_i_req;
                    w_arr_addr = i_spm_addr[SPM_AW-1:0];
                end else begin
                    w_i_serve  = 1'b0;
                    w_arr_addr = d_spm_addr[SPM_AW-1:0];
                end
            end
            SPM_ST_I_WAIT: begin
                spm_busy = w_d_req;
                if (!w_d_req) begin
                    w_i_serve  = 1'b1;
                    w_arr_addr = r_pend_addr;
                end else begin
                    w_i_serve  = 1'b0;
                    w_arr_addr = d_spm_addr[SPM_AW-1:0];
                end
            end
            default: begin
                spm_busy   = 1'b0;
                w_i_serve  = 1'b0;
                w_arr_addr = d_spm_addr[SPM_AW-1:0];
            end
        endcase
    end

    // FSM, pending fetch address and per-port read data registers (hold until next served read).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= SPM_ST_IDLE;
            r_pend_addr <= {SPM_AW{1'b0}};
            r_d_rd_data <= {WORD_DATA_W{1'b0}};
            r_i_rd_data <= {WORD_DATA_W{1'b0}};
        end else begin
            if (w_d_rd) begin
                r_d_rd_data <= w_arr_rdata;
            end
            if (w_i_serve) begin
                r_i_rd_data <= w_arr_rdata;
            end
            case (r_state)
                SPM_ST_IDLE: begin
                    if (w_d_req && w_i_req) begin
                        r_pend_addr <= i_spm_addr[SPM_AW-1:0];
                        r_state     <= SPM_ST_I_WAIT;
                    end
                end
                SPM_ST_I_WAIT: begin
                    if (!w_d_req) begin
                        r_state <= SPM_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= SPM_ST_IDLE;
                end
            endcase
        end
    end

`ifdef SPM_PARITY_EN
    logic w_arr_perr;
    logic r_parity_err;

    assign spm_parity_err = r_parity_err;

    // Sticky parity error, set by any served read of a corrupted word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_parity_err <= 1'b0;
        end else if ((w_d_rd | w_i_serve) & w_arr_perr) begin
            r_parity_err <= 1'b1;
        end
    end
`endif

    spm_resp_array #(
        .DEPTH (SPM_DEPTH),
        .AW    (SPM_AW)
    ) u_array (
        .clk     (clk),
        .i_we    (w_d_wr),
        .i_addr  (w_arr_addr),
        .i_wdata (d_spm_wr_data),
        .o_rdata (w_arr_rdata)
`ifdef SPM_PARITY_EN
        ,
        .o_perr  (w_arr_perr)
`endif
    );

endmodule

// File: tb/tb_spm_resp.sv
// Scoreboard bench for spm_resp: expected read data is queued per port when a read is served
// and popped after the clock edge; busy is checked against its equation every cycle.
module tb_spm_resp;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [29:0] d_spm_addr    = 30'd0;
    logic        d_spm_as_     = 1'b1;
    logic        d_spm_rw      = 1'b1;
    logic [31:0] d_spm_wr_data = 32'd0;
    logic [31:0] d_spm_rd_data;
    logic [29:0] i_spm_addr    = 30'd0;
    logic        i_spm_as_     = 1'b1;
    logic [31:0] i_spm_rd_data;
    logic        spm_busy;
`ifdef SPM_PARITY_EN
    logic        spm_parity_err;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] ref_mem [0:4095];
    logic [31:0] d_q [$];
    logic [31:0] i_q [$];
    logic [31:0] d_last = 32'd0;
    logic [31:0] i_last = 32'd0;
    logic        m_wait = 1'b0;
    logic [11:0] m_pend = 12'd0;

    spm_resp u_dut (
        .clk           (clk),
        .reset         (reset),
        .d_spm_addr    (d_spm_addr),
        .d_spm_as_     (d_spm_as_),
        .d_spm_rw      (d_spm_rw),
        .d_spm_wr_data (d_spm_wr_data),
        .d_spm_rd_data (d_spm_rd_data),
        .i_spm_addr    (i_spm_addr),
        .i_spm_as_     (i_spm_as_),
        .i_spm_rd_data (i_spm_rd_data),
        .spm_busy      (spm_busy)
`ifdef SPM_PARITY_EN
        ,
        .spm_parity_err(spm_parity_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive, check busy, model the cycle, clock, check both read ports.
    task automatic step(input logic das, input logic rw, input logic [29:0] da, input logic [31:0] wd,
                        input logic ias, input logic [29:0] ia);
        logic busy_exp;
        d_spm_as_     = das;
        d_spm_rw      = rw;
        d_spm_addr    = da;
        d_spm_wr_data = wd;
        i_spm_as_     = ias;
        i_spm_addr    = ia;
        #1;
        busy_exp = (!m_wait && !ias && !das) || (m_wait && !das);
        chk("busy", {31'd0, spm_busy}, {31'd0, busy_exp});
        if (!das && rw) d_q.push_back(ref_mem[da[11:0]]);
        if (!m_wait) begin
            if (!das && !ias) begin
                m_pend = ia[11:0];
                m_wait = 1'b1;
            end else if (das && !ias) begin
                i_q.push_back(ref_mem[ia[11:0]]);
            end
        end else if (das) begin
            i_q.push_back(ref_mem[m_pend]);
            m_wait = 1'b0;
        end
        if (!das && !rw) ref_mem[da[11:0]] = wd;
        @(posedge clk);
        #1;
        if (d_q.size() > 0) d_last = d_q.pop_front();
        if (i_q.size() > 0) i_last = i_q.pop_front();
        chk("d_rd", d_spm_rd_data, d_last);
        chk("i_rd", i_spm_rd_data, i_last);
    endtask

    task automatic wr(input logic [29:0] a, input logic [31:0] v);
        step(1'b0, 1'b0, a, v, 1'b1, 30'd0);
    endtask

    task automatic rd(input logic [29:0] a);
        step(1'b0, 1'b1, a, 32'd0, 1'b1, 30'd0);
    endtask

    task automatic idle();
        step(1'b1, 1'b1, 30'd0, 32'd0, 1'b1, 30'd0);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        d_spm_as_ = 1'b1;
        i_spm_as_ = 1'b1;
        @(posedge clk);
        #1;
        m_wait = 1'b0;
        m_pend = 12'd0;
        d_last = 32'd0;
        i_last = 32'd0;
        d_q.delete();
        i_q.delete();
        chk("rst_d_rd", d_spm_rd_data, 32'd0);
        chk("rst_i_rd", i_spm_rd_data, 32'd0);
        chk("rst_busy", {31'd0, spm_busy}, 32'd0);
`ifdef SPM_PARITY_EN
        chk("rst_perr", {31'd0, spm_parity_err}, 32'd0);
`endif
        reset = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // Write then read
        wr(30'h10, 32'hDEADBEEF);
        rd(30'h10);
        idle();

        // Collision: data wins, fetch deferred one cycle
        wr(30'h20, 32'h11111111);
        wr(30'h30, 32'h22222222);
        wr(30'h50, 32'h33333333);
        wr(30'h60, 32'h44444444);
        step(1'b0, 1'b1, 30'h20, 32'd0, 1'b0, 30'h30);
        step(1'b1, 1'b1, 30'd0, 32'd0, 1'b0, 30'h30);
        idle();

        // Starvation: three more data cycles, live fetch address changed meanwhile
        step(1'b0, 1'b1, 30'h10, 32'd0, 1'b0, 30'h50);
        step(1'b0, 1'b1, 30'h20, 32'd0, 1'b0, 30'h60);
        step(1'b0, 1'b0, 30'h70, 32'h55555555, 1'b0, 30'h60);
        step(1'b0, 1'b1, 30'h70, 32'd0, 1'b0, 30'h60);
        step(1'b1, 1'b1, 30'd0, 32'd0, 1'b0, 30'h60);
        idle();

        // Wrap modulo depth, and a fetch-only read through an aliased address
        wr(30'h1005, 32'hA5A5A5A5);
        rd(30'h0005);
        step(1'b1, 1'b1, 30'd0, 32'd0, 1'b0, 30'h3FFF_F010);
        idle();

        // Reset while a fetch is pending drops it
        step(1'b0, 1'b1, 30'h20, 32'd0, 1'b0, 30'h30);
        do_reset();
        idle();
        idle();

        // Randomised traffic over a small initialised window
        for (int k = 0; k < 16; k++) wr(30'(k), $urandom);
        for (int k = 0; k < 80; k++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 {18'($urandom), 12'($urandom_range(0, 15))}, $urandom,
                 1'($urandom_range(0, 1)),
                 {18'($urandom), 12'($urandom_range(0, 15))});
        end
        idle();

`ifdef SPM_PARITY_EN
        wr(30'h40, 32'h0F0F0F0F);
        rd(30'h40);
        chk("perr_clean", {31'd0, spm_parity_err}, 32'd0);
        u_dut.u_array.r_mem[64] = u_dut.u_array.r_mem[64] ^ 33'h0_0000_0008;
        ref_mem[64] = ref_mem[64] ^ 32'h0000_0008;
        rd(30'h40);
        chk("perr_set", {31'd0, spm_parity_err}, 32'd1);
        idle();
        rd(30'h10);
        chk("perr_sticky", {31'd0, spm_parity_err}, 32'd1);
        do_reset();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
